// File: rtl/booth_pkg.sv
// booth_pkg: shared state type and default widths for the Booth MAC datapath
package booth_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int LEN_W_DEF  = 4;
endpackage

// File: rtl/booth_sat_add.sv
// booth_sat_add: combinational signed adder with overflow flag;
// saturates instead of wrapping when BOOTH_ACC_SAT_EN is defined
module booth_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  logic signed [W-1:0] raw;
  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef BOOTH_ACC_SAT_EN
  // clamp toward the shared operand sign
  assign sum = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums a run of signed products and hands the total downstream.
// Optional BOOTH_ACC_SAT_EN makes the accumulator saturate on overflow.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [LEN_W-1:0]  len,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [PROD_W-1:0] prod_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic                     busy,
  output logic                     overflow
);
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic signed [ACC_W-1:0] acc, ext, sum;
  logic add_ovf, ovf, accept;
  assign ext    = ACC_W'(prod_data);
  assign accept = prod_valid && state == ACCUM;
  booth_sat_add #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (ext),
    .sum (sum),
    .ovf (add_ovf)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (prod_valid && cnt == LEN_W'(1)) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // accumulator is left untouched after a run so the last sum stays visible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt - 1'b1;
      ovf <= ovf | add_ovf;
    end
  end
  assign prod_ready = state == ACCUM;
  assign res_valid  = state == DONE;
  assign busy       = state != IDLE;
  assign res_data   = acc;
  assign overflow   = ovf;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: table-driven and random checks of a 16-bit and an 8-bit accumulator in lockstep
module tb_booth_product_accumulator;
  logic clk = 1'b0;
  logic rst_n, start, prod_valid, res_ready;
  logic [3:0] len;
  logic signed [7:0] prod_data;
  logic prod_ready, res_valid, busy, overflow;
  logic signed [15:0] res_data;
  logic s_prod_ready, s_res_valid, s_busy, s_overflow;
  logic signed [7:0] s_res_data;
  int total = 0, bad = 0;
  int m16, m8;
  bit o16, o8;
  int pv[16];

  always #5 clk = ~clk;

  booth_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .overflow(overflow)
  );

  booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .LEN_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_ready(s_prod_ready), .prod_data(prod_data),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
    .busy(s_busy), .overflow(s_overflow)
  );

  typedef struct {
    int n;
    int p[4];
    int vmask;
    int hold;
    int exp16;
    int exp8;
    int ovf8;
  } vec_t;
  vec_t vecs[4];

  // reference: exact integer sum, then wrap or clamp to a w-bit signed range
  function automatic int mdl_add(int acc, int p, int w);
    int lim = 1 << (w - 1);
    int s = acc + p;
`ifdef BOOTH_ACC_SAT_EN
    if (s >= lim) return lim - 1;
    if (s < -lim) return -lim;
`else
    if (s >= lim) return s - 2 * lim;
    if (s < -lim) return s + 2 * lim;
`endif
    return s;
  endfunction

  function automatic bit mdl_ovf(int acc, int p, int w);
    int lim = 1 << (w - 1);
    int s = acc + p;
    return s >= lim || s < -lim;
  endfunction

  function automatic vec_t mk(int n, int a, int b, int c, int d, int vmask, int hold, int e16, int e8, int ov8);
    vec_t v;
    v.n = n; v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.vmask = vmask; v.hold = hold; v.exp16 = e16; v.exp8 = e8; v.ovf8 = ov8;
    return v;
  endfunction

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero();
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst8_res_data", s_res_data, 0);
    chk("rst8_busy", s_busy, 0);
    chk("rst8_overflow", s_overflow, 0);
  endtask

  // drives one run of n products from pv; ends with both DUTs expected in DONE
  task automatic run(int n, int vmask, bit rnd, bit poke);
    int idx = 0, c = 0;
    bit v;
    m16 = 0; m8 = 0; o16 = 0; o8 = 0;
    start = 1'b1; len = 4'(n);
    tick();
    start = 1'b0; len = 4'($urandom);
    while (idx < n && c < 100) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : (c < 32 ? vmask[c] : 1'b1);
      chk("prod_ready", prod_ready, 1);
      chk("busy_accum", busy, 1);
      chk("res_valid_accum", res_valid, 0);
      start = poke && c == 1;
      len = 4'd7;
      prod_valid = v;
      prod_data = 8'(pv[idx]);
      tick();
      if (v) begin
        o16 |= mdl_ovf(m16, pv[idx], 16); m16 = mdl_add(m16, pv[idx], 16);
        o8  |= mdl_ovf(m8, pv[idx], 8);   m8  = mdl_add(m8, pv[idx], 8);
        idx++;
      end
      chk("running_sum", res_data, m16);
      chk("running_sum8", s_res_data, m8);
      c++;
    end
    start = 1'b0; prod_valid = 1'b0; prod_data = 8'($urandom);
    chk("products_taken", idx, n);
    chk("res_valid", res_valid, 1);
    chk("res_valid8", s_res_valid, 1);
    chk("prod_ready_done", prod_ready, 0);
    chk("busy_done", busy, 1);
    chk("res_data", res_data, m16);
    chk("res_data8", s_res_data, m8);
    chk("overflow", overflow, o16);
    chk("overflow8", s_overflow, o8);
  endtask

  task automatic finish_run(int hold, bit poke);
    repeat (hold) begin
      tick();
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, m16);
      chk("hold_overflow8", s_overflow, o8);
    end
    res_ready = 1'b1; start = poke; len = 4'd3;
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("after_res_valid", res_valid, 0);
    chk("after_busy", busy, 0);
    chk("after_res_data", res_data, m16);
    if (poke) begin
      tick();
      chk("poke_busy", busy, 0);
      chk("poke_prod_ready", prod_ready, 0);
      chk("poke_res_data", res_data, m16);
    end
  endtask

  initial begin
`ifdef BOOTH_ACC_SAT_EN
    int sat8 = 127;
`else
    int sat8 = -128;
`endif
    vecs[0] = mk(4, 6, -12, 20, 64, -1, 0, 78, 78, 0);
    vecs[1] = mk(0, 0, 0, 0, 0, -1, 5, 0, 0, 0);
    vecs[2] = mk(3, -8, -8, -1, 0, 32'b101001, 0, -17, -17, 0);
    vecs[3] = mk(2, 64, 64, 0, 0, -1, 0, 128, sat8, 1);
    rst_n = 1'b0; start = 1'b0; len = '0; prod_valid = 1'b0; prod_data = '0; res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_idle_zero();

    foreach (vecs[i]) begin
      for (int k = 0; k < 16; k++) pv[k] = (k < 4) ? vecs[i].p[k] : 0;
      run(vecs[i].n, vecs[i].vmask, 1'b0, 1'b0);
      chk("tbl_sum", res_data, vecs[i].exp16);
      chk("tbl_sum8", s_res_data, vecs[i].exp8);
      chk("tbl_ovf8", s_overflow, vecs[i].ovf8);
      chk("tbl_ovf16", overflow, 0);
      finish_run(vecs[i].hold, 1'b0);
    end

    // start pulses in ACCUM and in the result handshake cycle are both ignored
    pv[0] = 10; pv[1] = 20; pv[2] = 30;
    run(3, -1, 1'b0, 1'b1);
    chk("poke_sum", res_data, 60);
    finish_run(0, 1'b1);

    // reset in the middle of a run discards it
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_data = 8'sd9;
    tick();
    prod_data = -8'sd3;
    tick();
    prod_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle_zero();
    pv[0] = 5;
    run(1, -1, 1'b0, 1'b0);
    chk("post_reset_sum", res_data, 5);
    finish_run(0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 16; k++) pv[k] = int'($urandom_range(0, 255)) - 128;
      run(int'($urandom_range(0, 15)), 0, 1'b1, r[0]);
      finish_run(int'($urandom_range(0, 2)), r[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
